// File: rtl/led_debug_ctrl.sv
// led_debug_ctrl: board debug controller.
// Generates a programmable CPU clock-enable, HALT/RUN/STEP control from
// synchronized and debounced switch/buttons, and a paged LED view of a
// debug word. Optional macro LED_DEBUG_HEARTBEAT_EN replaces the top LED
// with a flop that toggles on every CPU clock-enable pulse.
module led_debug_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LED_WIDTH  = 16,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned PAGES      = DATA_WIDTH / LED_WIDTH,
  localparam int unsigned PAGE_WIDTH = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  sysClk,
  input  logic                  sysRes,
  input  logic [DATA_WIDTH-1:0] dbgWord,
  input  logic [DIV_WIDTH-1:0]  divSel,
  input  logic                  runSw,
  input  logic                  stepBtn,
  input  logic                  pageBtn,
  output logic                  cpuClkEn,
  output logic                  halted,
  output logic [LED_WIDTH-1:0]  leds,
  output logic [PAGE_WIDTH-1:0] page,
  output logic [CNT_WIDTH-1:0]  enCount
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PAGE_WIDTH-1:0] PAGE_LAST = PAGE_WIDTH'(PAGES - 1);

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP
  } state_t;

  // bit 0 = runSw, bit 1 = stepBtn, bit 2 = pageBtn
  logic [2:0]       rawIn;
  logic [2:0]       syncA, syncB, deb, accept;
  logic [DEB_W-1:0] debCnt [3];
  logic             stepPulse, pagePulse;

  state_t                state, state_n;
  logic [DIV_WIDTH-1:0]  divCnt, divCnt_n;
  logic                  tick, en_n;
  logic [LED_WIDTH-1:0]  ledsData;

  assign rawIn = {pageBtn, stepBtn, runSw};

  // debounce acceptance: Nth consecutive differing sample
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      accept[i] = (syncB[i] != deb[i]) && (debCnt[i] == DEB_LAST);
    end
  end

  // two-flop synchronizers, debounce counters and rising-edge pulses
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      syncA     <= '0;
      syncB     <= '0;
      deb       <= '0;
      stepPulse <= 1'b0;
      pagePulse <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) debCnt[i] <= '0;
    end else begin
      syncA     <= rawIn;
      syncB     <= syncA;
      stepPulse <= accept[1] & syncB[1];
      pagePulse <= accept[2] & syncB[2];
      for (int unsigned i = 0; i < 3; i++) begin
        if (accept[i]) begin
          deb[i]    <= syncB[i];
          debCnt[i] <= '0;
        end else if (syncB[i] != deb[i]) begin
          debCnt[i] <= debCnt[i] + 1'b1;
        end else begin
          debCnt[i] <= '0;
        end
      end
    end
  end

  // divider tick, FSM next state and clock-enable decision
  always_comb begin
    state_n = state;
    en_n    = 1'b0;
    tick    = (divCnt >= divSel);
    case (state)
      S_HALT: begin
        if (deb[0])         state_n = S_RUN;
        else if (stepPulse) state_n = S_STEP;
      end
      S_RUN: begin
        if (!deb[0]) state_n = S_HALT;
        else         en_n    = tick;
      end
      S_STEP: begin
        if (deb[0]) begin
          state_n = S_RUN;
        end else if (tick) begin
          en_n    = 1'b1;
          state_n = S_HALT;
        end
      end
      default: state_n = S_HALT;
    endcase
    divCnt_n = (tick || (state_n != state)) ? '0 : divCnt + 1'b1;
  end

  // state register, divider, registered enable/halted and pulse counter
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      state    <= S_HALT;
      divCnt   <= '0;
      cpuClkEn <= 1'b0;
      halted   <= 1'b1;
      enCount  <= '0;
    end else begin
      state    <= state_n;
      divCnt   <= divCnt_n;
      cpuClkEn <= en_n;
      halted   <= (state_n == S_HALT);
      if (cpuClkEn) enCount <= enCount + 1'b1;
    end
  end

  // page select and registered LED slice
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      page     <= PAGE_LAST;
      ledsData <= '0;
    end else begin
      if (pagePulse) page <= (page == PAGE_LAST) ? '0 : page + 1'b1;
      ledsData <= dbgWord[page*LED_WIDTH +: LED_WIDTH];
    end
  end

`ifdef LED_DEBUG_HEARTBEAT_EN
  logic heartbeat;

  // heartbeat toggles once per CPU clock-enable pulse
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes)       heartbeat <= 1'b0;
    else if (cpuClkEn) heartbeat <= ~heartbeat;
  end

  assign leds = {heartbeat, ledsData[LED_WIDTH-2:0]};
`else
  assign leds = ledsData;
`endif

endmodule

// File: tb/tb_led_debug_ctrl.sv
// Scoreboard bench for led_debug_ctrl: stimulus pushes expected cpuClkEn
// pulses (cycle, enCount), page updates and LED updates into queues; a
// monitor pops and compares whenever the DUT presents one of those events.
module tb_led_debug_ctrl;

  logic        sysClk = 1'b0;
  logic        sysRes;
  logic [31:0] dbgWord;
  logic [7:0]  divSel;
  logic        runSw, stepBtn, pageBtn;
  logic        cpuClkEn, halted;
  logic [15:0] leds;
  logic [0:0]  page;
  logic [15:0] enCount;

  led_debug_ctrl dut (
    .sysClk  (sysClk),
    .sysRes  (sysRes),
    .dbgWord (dbgWord),
    .divSel  (divSel),
    .runSw   (runSw),
    .stepBtn (stepBtn),
    .pageBtn (pageBtn),
    .cpuClkEn(cpuClkEn),
    .halted  (halted),
    .leds    (leds),
    .page    (page),
    .enCount (enCount)
  );

  always #5 sysClk = ~sysClk;

`ifdef LED_DEBUG_HEARTBEAT_EN
  localparam logic [15:0] LMASK = 16'h7FFF;
`else
  localparam logic [15:0] LMASK = 16'hFFFF;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t pulseQ[$];
  exp_t pageQ[$];
  exp_t ledsQ[$];

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic        monEn = 1'b0;
  logic [15:0] prevLeds;
  logic        prevPage;

  always @(posedge sysClk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge sysClk);
  endtask

  task automatic push(inout exp_t q[$], input int c, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask

  // monitor: compares each presented pulse / page change / LED change
  always @(negedge sysClk) begin
    exp_t e;
    if (monEn) begin
      if (cpuClkEn) begin
        if (pulseQ.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: cpuClkEn=1 at cycle %0d, expected none", cyc);
        end else begin
          e = pulseQ.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_enCount", {16'h0, enCount}, e.val);
        end
      end
      if (page !== prevPage) begin
        if (pageQ.size() == 0) begin
          checks++;
          $display("FAIL unexpected_page: page=%0d at cycle %0d, expected %0d", page, cyc, prevPage);
        end else begin
          e = pageQ.pop_front();
          chk("page_cycle", cyc, e.cyc);
          chk("page_value", {31'h0, page}, e.val);
        end
        prevPage = page;
      end
      if ((leds & LMASK) !== prevLeds) begin
        if (ledsQ.size() == 0) begin
          checks++;
          $display("FAIL unexpected_leds: leds=%0h at cycle %0d, expected %0h", leds & LMASK, cyc, prevLeds);
        end else begin
          e = ledsQ.pop_front();
          chk("leds_cycle", cyc, e.cyc);
          chk("leds_value", {16'h0, leds & LMASK}, e.val & {16'h0, LMASK});
        end
        prevLeds = leds & LMASK;
      end
    end
  end

  initial begin
    int t, cr;
    dbgWord = 32'hDEAD_BEEF;
    divSel  = 8'd0;
    runSw   = 1'b0;
    stepBtn = 1'b0;
    pageBtn = 1'b0;
    sysRes  = 1'b1;
    #2 sysRes = 1'b0;

    // reset values
    repeat (2) @(negedge sysClk);
    #1;
    chk("rst_halted", {31'h0, halted}, 1);
    chk("rst_cpuClkEn", {31'h0, cpuClkEn}, 0);
    chk("rst_leds", {16'h0, leds}, 0);
    chk("rst_page", {31'h0, page}, 1);
    chk("rst_enCount", {16'h0, enCount}, 0);

    @(negedge sysClk);
    t = cyc;
    sysRes   = 1'b1;
    prevLeds = 16'h0;
    prevPage = 1'b1;
    monEn    = 1'b1;
    push(ledsQ, t + 1, 32'hDEAD);
    wait_to(t + 20);
    chk("idle_halted", {31'h0, halted}, 1);
    chk("idle_enCount", {16'h0, enCount}, 0);

    // RUN with divSel=3, then divSel=0 while runSw drops
    t = cyc;
    divSel = 8'd3;
    runSw  = 1'b1;
    for (int k = 0; k < 10; k++) push(pulseQ, t + 11 + 4 * k, k);
    wait_to(t + 6);
    chk("run_entry_still_halted", {31'h0, halted}, 1);
    wait_to(t + 7);
    chk("run_entry_halted_low", {31'h0, halted}, 0);
    wait_to(t + 48);
    divSel = 8'd0;
    runSw  = 1'b0;
    for (int k = 0; k < 6; k++) push(pulseQ, t + 49 + k, 10 + k);
    wait_to(t + 54);
    chk("run_exit_still_running", {31'h0, halted}, 0);
    wait_to(t + 55);
    chk("run_exit_halted", {31'h0, halted}, 1);
    wait_to(t + 60);
    chk("run_enCount", {16'h0, enCount}, 16);

    // single step with divSel=2, then a short bounce
    t = cyc;
    divSel  = 8'd2;
    stepBtn = 1'b1;
    push(pulseQ, t + 10, 16);
    wait_to(t + 7);
    chk("step_state_not_halted", {31'h0, halted}, 0);
    wait_to(t + 8);
    stepBtn = 1'b0;
    wait_to(t + 10);
    chk("step_back_halted", {31'h0, halted}, 1);
    wait_to(t + 11);
    chk("step_enCount", {16'h0, enCount}, 17);
    wait_to(t + 30);
    stepBtn = 1'b1;
    wait_to(t + 32);
    stepBtn = 1'b0;
    wait_to(t + 55);
    chk("glitch_enCount", {16'h0, enCount}, 17);
    chk("glitch_halted", {31'h0, halted}, 1);

    // page button pressed three times
    t = cyc;
    dbgWord = 32'h1234_5678;
    push(ledsQ, t + 1, 32'h1234);
    for (int n = 0; n < 3; n++) begin
      push(pageQ, t + 2 + 20 * n + 7, (n % 2 == 0) ? 0 : 1);
      push(ledsQ, t + 2 + 20 * n + 8, (n % 2 == 0) ? 32'h5678 : 32'h1234);
    end
    for (int n = 0; n < 3; n++) begin
      wait_to(t + 2 + 20 * n);
      pageBtn = 1'b1;
      wait_to(t + 2 + 20 * n + 8);
      pageBtn = 1'b0;
    end
    wait_to(t + 72);
    dbgWord = 32'h0;
    push(ledsQ, cyc + 1, 32'h0);
    wait_to(t + 80);

    // reset asserted mid-run with divSel=0
    t = cyc;
    divSel = 8'd0;
    runSw  = 1'b1;
    for (int k = 0; k < 5; k++) push(pulseQ, t + 8 + k, 17 + k);
    wait_to(t + 7);
    chk("run2_halted_low", {31'h0, halted}, 0);
    wait_to(t + 12);
    cr = cyc;
    push(pageQ, cr + 1, 1);
    #2 sysRes = 1'b0;
    #1;
    chk("midrst_halted", {31'h0, halted}, 1);
    chk("midrst_cpuClkEn", {31'h0, cpuClkEn}, 0);
    chk("midrst_enCount", {16'h0, enCount}, 0);
    chk("midrst_leds", {16'h0, leds}, 0);
    chk("midrst_page", {31'h0, page}, 1);
    wait_to(cr + 1);
    #2 sysRes = 1'b1;
    for (int k = 0; k < 7; k++) push(pulseQ, cr + 9 + k, k);
    wait_to(cr + 7);
    chk("rerun_still_halted", {31'h0, halted}, 1);
    wait_to(cr + 8);
    chk("rerun_halted_low", {31'h0, halted}, 0);
    wait_to(cr + 9);
    runSw = 1'b0;
    wait_to(cr + 20);
    chk("rerun_exit_halted", {31'h0, halted}, 1);
    chk("rerun_enCount", {16'h0, enCount}, 7);

    // RUN with divSel=1, dbgWord=0: heartbeat or dark LEDs
    t = cyc;
    divSel = 8'd1;
    runSw  = 1'b1;
    for (int k = 0; k < 8; k++) push(pulseQ, t + 9 + 2 * k, 7 + k);
    wait_to(t + 7);
    chk("hb_run_halted_low", {31'h0, halted}, 0);
`ifdef LED_DEBUG_HEARTBEAT_EN
    for (int o = 0; o < 8; o++) begin
      wait_to(t + 10 + o);
      chk("hb_bit", {31'h0, leds[15]}, ((o / 2) % 2 == 0) ? 0 : 1);
      chk("hb_low_leds", {17'h0, leds[14:0]}, 0);
    end
`endif
    wait_to(t + 18);
    runSw = 1'b0;
    wait_to(t + 25);
    chk("hb_exit_halted", {31'h0, halted}, 1);
    wait_to(t + 30);
    chk("hb_enCount", {16'h0, enCount}, 15);
`ifndef LED_DEBUG_HEARTBEAT_EN
    chk("dark_leds", {16'h0, leds}, 0);
`endif

    chk("pulse_queue_drained", pulseQ.size(), 0);
    chk("page_queue_drained", pageQ.size(), 0);
    chk("leds_queue_drained", ledsQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
